// File: rtl/disc_writer_pkg.sv
// Shared definitions for the floppy write-timing engine: state encoding,
// byte-format constants and the interval decode helper.
package disc_writer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAITIDX,
        START,
        COUNT,
        DONE
    } state_t;

    localparam logic [7:0] END_OF_TRACK = 8'h00;
    localparam int         PULSE_BIT    = 7;
    localparam int         COUNT_WIDTH  = 7;

    // A pulse-bearing byte with a zero length still needs one tick to fire.
    function automatic logic [COUNT_WIDTH-1:0] interval_length(input logic [7:0] code);
        logic [COUNT_WIDTH-1:0] n;
        n = code[COUNT_WIDTH-1:0];
        if (n == '0 && code[PULSE_BIT]) begin
            n = COUNT_WIDTH'(1);
        end
        return n;
    endfunction

endpackage

// File: rtl/disc_writer_if.sv
// Show-ahead FIFO read port consumed by the write-timing engine.
interface disc_writer_if;

    logic [7:0] data;
    logic       empty;
    logic       read;

    modport master (input data, input empty, output read);
    modport slave  (output data, output empty, input read);

endinterface

// File: rtl/disc_writer_pulsegen.sv
// Retriggerable one-shot that stretches a single-cycle trigger into a
// PULSE_WIDTH-clock write-data pulse.
module disc_writer_pulsegen #(
    parameter int PULSE_WIDTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trigger,
    output logic pulse
);

    localparam int CW = $clog2(PULSE_WIDTH + 1);

    logic [CW-1:0] remaining;

    // Retriggering reloads the full width, so back-to-back pulses merge cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
        end else if (trigger) begin
            remaining <= CW'(PULSE_WIDTH);
        end else if (remaining != '0) begin
            remaining <= remaining - CW'(1);
        end
    end

    assign pulse = (remaining != '0);

endmodule

// File: rtl/disc_writer.sv
// Floppy write-timing engine: turns a stream of interval bytes from a FIFO
// into write-data pulses under a write gate, optionally index-aligned.
module disc_writer
    import disc_writer_pkg::*;
#(
    parameter int PULSE_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clken,
    input  logic                 run,
    input  logic                 wait_index,
    input  logic                 fd_index_in,
    disc_writer_if.master        fifo,
    output logic                 fd_wrdata_out,
    output logic                 fd_wrgate_out,
    output logic                 busy,
    output logic                 done,
    output logic                 underrun
);

    state_t                 state, state_next;
    logic [COUNT_WIDTH-1:0] counter, counter_next;
    logic                   pulse_flag, pulse_flag_next;
    logic                   gate, gate_next;
    logic                   underrun_q, underrun_next;
    logic                   pop;
    logic                   fire;

    logic                   idx_meta, idx_sync, idx_prev;
    logic                   index_edge;

    // Index pulse is asynchronous: two-flop synchroniser then edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_meta <= 1'b0;
            idx_sync <= 1'b0;
            idx_prev <= 1'b0;
        end else begin
            idx_meta <= fd_index_in;
            idx_sync <= idx_meta;
            idx_prev <= idx_sync;
        end
    end

    assign index_edge = idx_sync & ~idx_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            counter    <= '0;
            pulse_flag <= 1'b0;
            gate       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state      <= state_next;
            counter    <= counter_next;
            pulse_flag <= pulse_flag_next;
            gate       <= gate_next;
            underrun_q <= underrun_next;
        end
    end

    always_comb begin
        state_next      = state;
        counter_next    = counter;
        pulse_flag_next = pulse_flag;
        gate_next       = gate;
        underrun_next   = underrun_q;
        pop             = 1'b0;
        fire            = 1'b0;

        if (!run) begin
            if (state != IDLE) begin
                state_next = IDLE;
                gate_next  = 1'b0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    underrun_next = 1'b0;
                    state_next    = wait_index ? WAITIDX : START;
                end

                WAITIDX: begin
                    if (index_edge) begin
                        state_next = START;
                    end
                end

                START: begin
                    if (!fifo.empty) begin
                        pop = 1'b1;
                        if (fifo.data == END_OF_TRACK) begin
                            state_next = DONE;
                        end else begin
                            counter_next    = interval_length(fifo.data);
                            pulse_flag_next = fifo.data[PULSE_BIT];
                            gate_next       = 1'b1;
                            state_next      = COUNT;
                        end
                    end
                end

                // The next byte is loaded on the very edge that ends the
                // current interval so pulse spacing stays exact.
                COUNT: begin
                    if (clken) begin
                        if (counter == COUNT_WIDTH'(1)) begin
                            fire = pulse_flag;
                            if (!fifo.empty) begin
                                pop = 1'b1;
                                if (fifo.data == END_OF_TRACK) begin
                                    gate_next  = 1'b0;
                                    state_next = DONE;
                                end else begin
                                    counter_next    = interval_length(fifo.data);
                                    pulse_flag_next = fifo.data[PULSE_BIT];
                                end
                            end else begin
                                underrun_next = 1'b1;
                                gate_next     = 1'b0;
                                state_next    = DONE;
                            end
                        end else begin
                            counter_next = counter - COUNT_WIDTH'(1);
                        end
                    end
                end

                DONE: begin
                    state_next = DONE;
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    disc_writer_pulsegen #(
        .PULSE_WIDTH (PULSE_WIDTH)
    ) u_pulsegen (
        .clk     (clk),
        .rst_n   (rst_n),
        .trigger (fire),
        .pulse   (fd_wrdata_out)
    );

    // Gate and busy follow run combinationally so an abort takes effect at once.
    assign fifo.read     = pop;
    assign fd_wrgate_out = gate & run;
    assign busy          = run && (state == WAITIDX || state == START || state == COUNT);
    assign done          = (state == DONE);
    assign underrun      = underrun_q;

endmodule

// File: doc/disc_writer.md
DISC_WRITER -- requirements
Module: disc_writer

Interface
REQ-001 Parameter PULSE_WIDTH, default 4: width of each FD_WRDATA_OUT pulse, in CLOCK cycles.
REQ-002 CLOCK  in  1  single system clock; all state changes occur on its rising edge.
REQ-003 RESET  in  1  asynchronous, active-low reset.
REQ-004 CLKEN  in  1  timebase enable; interval counting advances only on cycles where CLKEN=1.
REQ-005 RUN  in  1  level; 1 = perform a write session, 0 = abort or idle.
REQ-006 WAIT_INDEX  in  1  1 = defer the session start until the next rising edge of the index signal.
REQ-007 FD_INDEX_IN  in  1  drive index pulse; asynchronous to CLOCK.
REQ-008 DATA  in  8  timing byte from a show-ahead FIFO; valid whenever EMPTY=0.
REQ-009 EMPTY  in  1  FIFO empty flag.
REQ-010 READ  out  1  FIFO pop strobe; one byte is consumed at each rising edge where READ=1.
REQ-011 FD_WRDATA_OUT  out  1  write-data pulse output.
REQ-012 FD_WRGATE_OUT  out  1  drive write gate.
REQ-013 BUSY  out  1  high while in states WAITIDX, START or COUNT.
REQ-014 DONE  out  1  high in state DONE.
REQ-015 UNDERRUN  out  1  sticky flag: the FIFO ran dry mid-session.

Function
REQ-016 Byte format: DATA[6:0] = interval length N in CLKEN cycles; DATA[7] = emit a pulse when the interval ends.
- N=0 with DATA[7]=1 is treated as N=1.
- 0x00 is the end-of-track terminator.
REQ-017 The FSM states SHALL be IDLE, WAITIDX, START, COUNT and DONE.
REQ-018 IDLE:
- RUN=1 and WAIT_INDEX=0 -> START.
- RUN=1 and WAIT_INDEX=1 -> WAITIDX.
REQ-019 FD_INDEX_IN SHALL pass through a 2-flop synchroniser followed by a rising-edge detector; WAITIDX -> START on the detected edge.
REQ-020 START, EMPTY=0:
- READ=1 combinationally.
- If the byte is 0x00, go to DONE.
- Otherwise, on the same edge, load the counter with N, latch DATA[7], set FD_WRGATE_OUT=1 and go to COUNT.
REQ-021 START, EMPTY=1: remain in START and assert no flag.
REQ-022 COUNT: the 7-bit counter decrements on each CLKEN=1 cycle; the final cycle is counter==1 with CLKEN=1.
REQ-023 On the final cycle with EMPTY=0:
- READ=1 and the next byte is loaded on the same edge, with zero idle cycles between bytes.
- If that byte is 0x00, go to DONE and drop FD_WRGATE_OUT at that edge.
REQ-024 On the final cycle with EMPTY=1: set UNDERRUN=1, drop FD_WRGATE_OUT and go to DONE.
REQ-025 If the latched DATA[7]=1, FD_WRDATA_OUT rises at the edge ending the final cycle and stays high for PULSE_WIDTH CLOCK cycles, independent of CLKEN.
REQ-026 A new pulse that begins while the previous pulse is still active restarts the width counter; the output stays high with no glitch.
REQ-027 Pulse spacing SHALL equal the sum of N over all bytes up to and including the pulse-bearing byte, in CLKEN cycles, exactly.
REQ-028 RUN=0 in any state other than IDLE -> IDLE at the next edge:
- FD_WRGATE_OUT, READ and BUSY go low immediately.
- An in-progress pulse completes its width.
REQ-029 DONE: DONE=1 and no further FIFO reads; RUN=0 -> IDLE.
REQ-030 UNDERRUN SHALL clear only on reset or on the IDLE->START/WAITIDX transition.
REQ-031 READ SHALL never be asserted while EMPTY=1.

Reset
REQ-032 On RESET=0, asynchronously: state=IDLE, counter=0, pulse counter=0, synchroniser flops=0, FD_WRDATA_OUT=0, FD_WRGATE_OUT=0, UNDERRUN=0.
REQ-033 During reset, READ, BUSY and DONE SHALL be 0.
REQ-034 Release from reset SHALL take effect at the first rising edge after RESET=1.

Structure
REQ-035 A shared package SHALL hold:
- the state encoding;
- the end-of-track code 0x00;
- the pulse-flag bit index (7);
- the count-field width (7).
REQ-036 One sub-module, disc_writer_pulsegen, SHALL contain the retriggerable PULSE_WIDTH one-shot; all other logic is in disc_writer.

Verification
REQ-037 FIFO={0x85,0x85,0x00}, CLKEN=1, WAIT_INDEX=0, RUN=1:
- two pulses, 5 clocks apart;
- each pulse 4 clocks wide;
- FD_WRGATE_OUT high for 10 clocks;
- DONE=1, UNDERRUN=0.
REQ-038 FIFO={0x7F,0x7F,0x83,0x00}: a single pulse 257 clocks after FD_WRGATE_OUT rises.
REQ-039 FIFO={0x81,0x81,0x81,0x00} with PULSE_WIDTH=4: FD_WRDATA_OUT stays high continuously from the first pulse until 4 clocks after the third.
REQ-040 FIFO={0x84} only (no terminator):
- pulse emitted after 4 clocks;
- then UNDERRUN=1, FD_WRGATE_OUT=0, DONE=1.
REQ-041 CLKEN toggling 1/0 each clock with FIFO={0x86,0x00}: pulse 12 CLOCK cycles after gate rise.
REQ-042 WAIT_INDEX=1: no READ until FD_INDEX_IN rises; FD_WRGATE_OUT rises at most 4 clocks after the index edge.
REQ-043 RUN dropped mid-byte: FD_WRGATE_OUT goes low next edge and the FIFO is not popped further.
REQ-044 RESET asserted mid-session: all outputs go 0 without a clock edge.
